dca_matrix_row_loader: RTL
==========================

DCA_MATRIX_ROW_LOADER -- requirements
Module: dca_matrix_row_loader

Interface
REQ-001 SHALL have parameter MATRIX_SIZE_PARA, default 8, meaning matrix dimension N (rows = columns = N).
REQ-002 SHALL have parameter BW_TENSOR_SCALAR, default 32, meaning the width of one matrix element.
REQ-003 SHALL define derived widths: BW_TENSOR_ROW = N*BW_TENSOR_SCALAR and BW_INDEX = clog2(N), minimum 1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port rstpp, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begin loading one N x N matrix.
REQ-007 SHALL have port abort, input, 1 bit: synchronous cancel of the current load.
REQ-008 SHALL have port scalar_valid, input, 1 bit: an upstream element is offered.
REQ-009 SHALL have port scalar_ready, output, 1 bit: the loader accepts the offered element.
REQ-010 SHALL have port scalar_data, input, BW_TENSOR_SCALAR bits: the element value, row-major order.
REQ-011 SHALL have port move_wenable, output, 1 bit: one-cycle row write strobe to the matrix register.
REQ-012 SHALL have port move_wdata_list, output, BW_TENSOR_ROW bits: the packed row; column 0 occupies the LSBs.
REQ-013 SHALL have port move_row_index, output, BW_INDEX bits: the row number qualified by move_wenable.
REQ-014 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse when the full matrix has been written.

Function
REQ-016 SHALL implement the FSM states IDLE, FILL, WRITE and DONE.
REQ-017 SHALL, in IDLE with start=1 and abort=0, clear the row register and both counters and enter FILL on the next cycle.
REQ-018 SHALL ignore start in every state other than IDLE.
REQ-019 SHALL drive scalar_ready=1 only in FILL; a handshake is scalar_valid & scalar_ready.
REQ-020 SHALL, on each handshake, store scalar_data into column col of the row register and increment col.
REQ-021 SHALL, on the handshake with col = N-1, wrap col to 0 and enter WRITE, so the strobe appears 1 cycle after the last element.
REQ-022 SHALL, in WRITE, assert move_wenable for exactly one cycle with move_wdata_list = row register and move_row_index = row.
REQ-023 SHALL leave WRITE for DONE when row = N-1; otherwise it SHALL increment row and return to FILL.
REQ-024 SHALL, in DONE, assert done for one cycle and then enter IDLE.
REQ-025 SHALL hold move_wdata_list stable outside WRITE; it reflects the row register.
REQ-026 SHALL, with continuous scalar_valid, reach done exactly N*(N+1)+1 cycles after the start cycle.
REQ-027 SHALL give abort priority over every other event: next state IDLE, counters cleared, no move_wenable and no done in the following cycle.
REQ-028 SHALL drop an element that handshakes in the same cycle as abort.
REQ-029 SHALL, when start and abort are both asserted in IDLE, remain in IDLE.
REQ-030 SHALL, when N = 1, make every handshake produce a WRITE and the first WRITE be followed by DONE.

Reset
REQ-031 SHALL, on rstpp=1 and independent of clk, set state=IDLE and clear col, row and the row register.
REQ-032 SHALL hold scalar_ready, move_wenable, move_row_index, move_wdata_list, busy and done at 0 during reset.
REQ-033 SHALL, when reset is asserted mid-load, discard the partial matrix; no done is issued for it.

Structure
REQ-034 SHALL take BW_TENSOR_ROW and the dimension utility function from the shared DCA matrix dimension include files.
REQ-035 SHALL place the FSM state encodings in a shared DCA localparam include so that loader and drainer stay consistent.
REQ-036 SHALL remain a single flat module with no sub-module, because the counters and packer are trivial.

Verification
REQ-037 SHALL cover, with N=4 and BW=8, start followed by elements 0x00..0x0F held valid: move_wenable in 4 cycles with rows 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, indices 0..3, and done at cycle 21.
REQ-038 SHALL cover scalar_valid toggled 1/0 every cycle: the same four rows, with done delayed accordingly and no extra strobes.
REQ-039 SHALL cover abort asserted on the handshake of the 6th element: no further move_wenable, busy=0 the next cycle, no done, and a restart reloading row 0 from scratch.
REQ-040 SHALL cover start pulsed in FILL and in WRITE: no effect on counters or on the output sequence.
REQ-041 SHALL cover rstpp asserted asynchronously mid-FILL: all outputs 0 immediately, and a subsequent load that is correct.
REQ-042 SHALL cover N=1 with elements 0xAA then 0xBB: for each load, move_wenable 1 cycle after the handshake carrying that element at index 0, then done.

Source files
------------

// File: rtl/dca_matrix_row_loader_pkg.sv
// Shared DCA matrix dimension helpers and loader/drainer FSM encodings.
package dca_matrix_row_loader_pkg;

  // FSM encodings, shared so the loader and drainer decode states identically
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } dca_ld_state_t;

  // Row/column index width; a 1x1 matrix still needs a 1-bit index
  function automatic int unsigned dca_index_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of one packed matrix row
  function automatic int unsigned dca_row_width(input int unsigned n, input int unsigned bw);
    return n * bw;
  endfunction

endpackage

// File: rtl/dca_matrix_row_loader.sv
// Packs a row-major scalar stream into N-element rows and writes each row
// into the matrix register with a one-cycle strobe; pulses done after row N-1.
module dca_matrix_row_loader
  import dca_matrix_row_loader_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE_PARA = 8,
  parameter int unsigned BW_TENSOR_SCALAR = 32,
  localparam int unsigned BW_TENSOR_ROW   = dca_row_width(MATRIX_SIZE_PARA, BW_TENSOR_SCALAR),
  localparam int unsigned BW_INDEX        = dca_index_width(MATRIX_SIZE_PARA)
) (
  input  logic                        clk,
  input  logic                        rstpp,
  input  logic                        start,
  input  logic                        abort,
  input  logic                        scalar_valid,
  output logic                        scalar_ready,
  input  logic [BW_TENSOR_SCALAR-1:0] scalar_data,
  output logic                        move_wenable,
  output logic [BW_TENSOR_ROW-1:0]    move_wdata_list,
  output logic [BW_INDEX-1:0]         move_row_index,
  output logic                        busy,
  output logic                        done
);

  localparam logic [BW_INDEX-1:0] LAST_IDX = BW_INDEX'(MATRIX_SIZE_PARA - 1);

  dca_ld_state_t            state;
  logic [BW_INDEX-1:0]      col;
  logic [BW_INDEX-1:0]      row;
  logic [BW_TENSOR_ROW-1:0] row_q;

  logic handshake;
  logic last_col;
  logic last_row;

  assign handshake = scalar_valid & scalar_ready;
  assign last_col  = (col == LAST_IDX);
  assign last_row  = (row == LAST_IDX);

  // Row register and row counter feed the write port directly; both are flops
  assign move_wdata_list = row_q;
  assign move_row_index  = row;

  // Loader FSM with counters, packer and registered outputs
  always_ff @(posedge clk or posedge rstpp) begin
    if (rstpp) begin
      state        <= ST_IDLE;
      col          <= '0;
      row          <= '0;
      row_q        <= '0;
      scalar_ready <= 1'b0;
      move_wenable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      move_wenable <= 1'b0;
      done         <= 1'b0;
      if (abort) begin
        // Cancel wins over everything, including an element handshaking now
        state        <= ST_IDLE;
        col          <= '0;
        row          <= '0;
        scalar_ready <= 1'b0;
        busy         <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start) begin
              state        <= ST_FILL;
              col          <= '0;
              row          <= '0;
              row_q        <= '0;
              scalar_ready <= 1'b1;
              busy         <= 1'b1;
            end
          end
          ST_FILL: begin
            if (handshake) begin
              row_q[BW_TENSOR_SCALAR*int'(col) +: BW_TENSOR_SCALAR] <= scalar_data;
              if (last_col) begin
                col          <= '0;
                state        <= ST_WRITE;
                scalar_ready <= 1'b0;
                move_wenable <= 1'b1;
              end else begin
                col <= col + BW_INDEX'(1);
              end
            end
          end
          ST_WRITE: begin
            if (last_row) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              row          <= row + BW_INDEX'(1);
              state        <= ST_FILL;
              scalar_ready <= 1'b1;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state        <= ST_IDLE;
            scalar_ready <= 1'b0;
            busy         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
